somador_serial_4bits: RTL and testbench

- Bit-serial adder: the inverse operation of the ripple subtractor in the 4-bit ALU datapath.
- Computes S = A + B one bit per clock through a single full-adder cell, LSB first.
- Controlled by a start/busy/done handshake.
- Gives the ALU a low-area add path that can be shared with a sequential controller.

---
 rtl/somador_serial_4bits.sv | 110 +++++++++++
 tb/tb_somador_serial_4bits.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/somador_serial_4bits.sv
// Bit-serial adder: S = A + B computed LSB first through one full-adder cell,
// with a start/busy/done handshake. Define SOMADOR_SERIAL_OVF_EN to add the Ovf output.
module somador_serial_4bits #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef SOMADOR_SERIAL_OVF_EN
  output logic             Ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sha_q, shb_q, sum_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic             ovf_q;
`endif

  logic             sum_bit, carry_d;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    sum_bit = sha_q[0] ^ shb_q[0] ^ carry_q;
    carry_d = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);
    sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sha_q   <= '0;
      shb_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        // Leaving DONE is the edge at which IDLE is reached, so a pending start
        // is taken there to give one result every WIDTH+1 cycles.
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            sha_q   <= A;
            shb_q   <= B;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            s_q     <= sum_d;
            cout_q  <= carry_d;
`ifdef SOMADOR_SERIAL_OVF_EN
            // carry_q is the carry into the MSB on this last bit
            ovf_q   <= carry_q ^ carry_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SOMADOR_SERIAL_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial_4bits.sv
// Self-checking bench for somador_serial_4bits: behavioural timeline model with a
// per-cycle compare, directed literal checks and randomized stimulus.
module tb_somador_serial_4bits;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] S;
  logic         Cout, busy, done;
`ifdef SOMADOR_SERIAL_OVF_EN
  logic         Ovf, Ovf8;
`endif

  logic         start8 = 1'b0;
  logic [7:0]   A8 = '0, B8 = '0, S8;
  logic         Cout8, busy8, done8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  somador_serial_4bits #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .S(S), .Cout(Cout),
`ifdef SOMADOR_SERIAL_OVF_EN
    .Ovf(Ovf),
`endif
    .busy(busy), .done(done)
  );

  somador_serial_4bits #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .S(S8), .Cout(Cout8),
`ifdef SOMADOR_SERIAL_OVF_EN
    .Ovf(Ovf8),
`endif
    .busy(busy8), .done(done8)
  );

  // Model: m_ctr = -1 when idle, else edges since acceptance (W means the done cycle).
  int           m_ctr;
  logic [W:0]   m_pend, m_res;
  logic         m_vpend, m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctr <= -1;
      m_res <= '0;
      m_v   <= 1'b0;
    end else if ((m_ctr == -1 || m_ctr == W) && start) begin
      m_ctr   <= 0;
      m_pend  <= {1'b0, A} + {1'b0, B};
      m_vpend <= (A[W-1] == B[W-1]) && (((A + B) >> (W - 1)) % 2 != A[W-1]);
    end else if (m_ctr == W) begin
      m_ctr <= -1;
    end else if (m_ctr >= 0) begin
      m_ctr <= m_ctr + 1;
      if (m_ctr == W - 1) begin
        m_res <= m_pend;
        m_v   <= m_vpend;
      end
    end
  end

  wire m_busy = (m_ctr >= 0) && (m_ctr < W);
  wire m_done = (m_ctr == W);

  always @(negedge clk) begin
    vectors++;
    if ({Cout, S, busy, done} !== {m_res, m_busy, m_done}) begin
      miscompares++;
      $display("FAIL cycle t=%0t got S=%0d Cout=%0b busy=%0b done=%0b want S=%0d Cout=%0b busy=%0b done=%0b",
               $time, S, Cout, busy, done, m_res[W-1:0], m_res[W], m_busy, m_done);
    end
`ifdef SOMADOR_SERIAL_OVF_EN
    vectors++;
    if (Ovf !== m_v) begin
      miscompares++;
      $display("FAIL ovf t=%0t got %0b want %0b", $time, Ovf, m_v);
    end
`endif
  end

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Issue one operation; returns edges from acceptance to done (-1 on timeout).
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("done_timeout", (lat < 0) ? 1 : 0, 0);
  endtask

  int lat, pulses, t_prev, gaps_ok;

  initial begin
    #23 rst_n = 1'b1;
    chk("reset_S", S, 0);
    chk("reset_busy", busy, 0);

    // Pin the model itself against hand-computed sums
    op(4'd5, 4'd3, lat);
    chk("lat_5p3", lat, W); chk("S_5p3", S, 8); chk("C_5p3", Cout, 0);
    chk("model_5p3", m_res, 8);
    @(posedge clk); #1 chk("done_once", done, 0);

    op(4'd15, 4'd1, lat); chk("S_15p1", S, 0);  chk("C_15p1", Cout, 1);
    op(4'd9, 4'd7, lat);  chk("S_9p7", S, 0);   chk("C_9p7", Cout, 1);
    op(4'd0, 4'd0, lat);  chk("lat_0p0", lat, W); chk("C_0p0", Cout, 0);
`ifdef SOMADOR_SERIAL_OVF_EN
    op(4'd7, 4'd1, lat); chk("S_7p1", S, 8); chk("V_7p1", Ovf, 1); chk("C_7p1", Cout, 0);
    op(4'd8, 4'd8, lat); chk("S_8p8", S, 0); chk("V_8p8", Ovf, 1); chk("C_8p8", Cout, 1);
    op(4'd3, 4'd2, lat); chk("V_3p2", Ovf, 0);
`endif

    // Start while busy is ignored
    @(posedge clk); #1 A = 4'd2; B = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 A = 4'd15; B = 4'd15; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("busy_ignore_S", S, 4); chk("busy_ignore_pulses", pulses, 1);

    // Asynchronous reset after two processed bits
    @(posedge clk); #1 A = 4'd6; B = 4'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_S", S, 0); chk("rst_C", Cout, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    #10 rst_n = 1'b1;
    op(4'd1, 4'd1, lat); chk("S_after_rst", S, 2);

    // start held high: results every W+1 cycles
    @(posedge clk); #1 A = 4'd3; B = 4'd4; start = 1'b1;
    pulses = 0; t_prev = -1; gaps_ok = 1;
    for (int i = 0; i < 4 * (W + 1) + 2; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (S != 4'd7) gaps_ok = 0;
        if (t_prev >= 0 && i - t_prev != W + 1) gaps_ok = 0;
        t_prev = i;
        pulses++;
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 4); chk("held_gaps", gaps_ok, 1);
    repeat (W + 2) @(posedge clk);

    // Randomized traffic including starts while busy and occasional resets
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      A = W'($urandom); B = W'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // WIDTH=8 instance: 200+100
    @(posedge clk); #1 A8 = 8'd200; B8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk("w8_lat", lat, 8); chk("w8_S", S8, 44); chk("w8_C", Cout8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
